// File: rtl/cr16_control_fsm.sv
// CR16 control sequencer: fetch/decode/execute FSM driving the datapath
// control bundle, program counter and conditional branch resolution.
module cr16_control_fsm (
    input  logic        I_CLK,
    input  logic        I_NRESET,
    input  logic        I_ENABLE,
    output logic        O_INSTR_REQ,
    output logic [15:0] O_INSTR_ADDR,
    input  logic        I_INSTR_VALID,
    input  logic [15:0] I_INSTRUCTION,
    input  logic [4:0]  I_STATUS_FLAGS,
    output logic [15:0] O_REG_WRITE_ENABLE,
    output logic [3:0]  O_REG_A_SELECT,
    output logic [3:0]  O_REG_B_SELECT,
    output logic        O_IMMEDIATE_SELECT,
    output logic [15:0] O_IMMEDIATE,
    output logic [3:0]  O_OPCODE,
    output logic        O_HALTED,
    output logic        O_ILLEGAL
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;

    logic [3:0]  cls;
    logic [3:0]  rd;
    logic [3:0]  ext;
    logic [3:0]  rs;
    logic [7:0]  imm8;
    logic [15:0] sext8;
    logic [15:0] zext8;
    logic [15:0] target;

    logic        writes;
    logic        is_branch;
    logic        is_halt;
    logic        is_illegal;
    logic        taken;
    logic        exec;

    assign cls    = ir[15:12];
    assign rd     = ir[11:8];
    assign ext    = ir[7:4];
    assign rs     = ir[3:0];
    assign imm8   = ir[7:0];
    assign sext8  = {{8{imm8[7]}}, imm8};
    assign zext8  = {8'h00, imm8};
    assign target = pc + sext8;

    always_comb begin
        writes             = 1'b0;
        is_branch          = 1'b0;
        is_halt            = 1'b0;
        is_illegal         = 1'b0;
        O_REG_A_SELECT     = 4'h0;
        O_REG_B_SELECT     = 4'h0;
        O_IMMEDIATE_SELECT = 1'b0;
        O_IMMEDIATE        = 16'h0000;
        O_OPCODE           = 4'h0;
        case (cls)
            4'h0: begin
                O_OPCODE       = ext;
                O_REG_A_SELECT = rd;
                O_REG_B_SELECT = rs;
                writes         = (ext != 4'b1011);
            end
            4'h1, 4'h9, 4'h2, 4'h3, 4'hB: begin
                O_REG_A_SELECT     = rd;
                O_IMMEDIATE_SELECT = 1'b1;
                writes             = 1'b1;
                case (cls)
                    4'h1:    begin O_OPCODE = 4'b0000; O_IMMEDIATE = sext8; end
                    4'h9:    begin O_OPCODE = 4'b0100; O_IMMEDIATE = sext8; end
                    4'h2:    begin O_OPCODE = 4'b0110; O_IMMEDIATE = zext8; end
                    4'h3:    begin O_OPCODE = 4'b0111; O_IMMEDIATE = zext8; end
                    default: begin O_OPCODE = 4'b1000; O_IMMEDIATE = zext8; end
                endcase
            end
            4'hC:    is_branch  = 1'b1;
            4'hF:    is_halt    = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    // Flags are {C,L,F,Z,N}; the rd field carries the condition code.
    always_comb begin
        case (rd)
            4'd0:    taken = I_STATUS_FLAGS[1];
            4'd1:    taken = !I_STATUS_FLAGS[1];
            4'd2:    taken = I_STATUS_FLAGS[4];
            4'd3:    taken = !I_STATUS_FLAGS[4];
            4'd4:    taken = I_STATUS_FLAGS[3];
            4'd5:    taken = !I_STATUS_FLAGS[3];
            4'd6:    taken = I_STATUS_FLAGS[0];
            4'd7:    taken = !I_STATUS_FLAGS[0];
            4'd14:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign exec               = (state == S_EXECUTE) && I_ENABLE;
    assign O_INSTR_REQ        = (state == S_FETCH) && I_ENABLE;
    assign O_INSTR_ADDR       = pc;
    assign O_REG_WRITE_ENABLE = (exec && writes) ? (16'h0001 << rd) : 16'h0000;
    assign O_ILLEGAL          = exec && is_illegal;
    assign O_HALTED           = (state == S_HALT);

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state <= S_IDLE;
            pc    <= 16'h0000;
            ir    <= 16'h0000;
        end else if (I_ENABLE) begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (I_INSTR_VALID) begin
                        ir    <= I_INSTRUCTION;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXECUTE;
                S_EXECUTE: begin
                    if (is_halt) begin
                        state <= S_HALT;
                    end else begin
                        pc    <= (is_branch && taken) ? target : pc + 16'h0001;
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Bench for cr16_control_fsm: directed and random instructions checked
// against an instruction-level reference model.
module tb_cr16_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic [15:0] we;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic        imm_sel;
    logic [15:0] imm;
    logic [3:0]  op;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    logic [15:0] mpc;

    always #5 clk = ~clk;

    cr16_control_fsm dut (
        .I_CLK(clk),
        .I_NRESET(rst_n),
        .I_ENABLE(enable),
        .O_INSTR_REQ(req),
        .O_INSTR_ADDR(addr),
        .I_INSTR_VALID(valid),
        .I_INSTRUCTION(instr),
        .I_STATUS_FLAGS(flags),
        .O_REG_WRITE_ENABLE(we),
        .O_REG_A_SELECT(a_sel),
        .O_REG_B_SELECT(b_sel),
        .O_IMMEDIATE_SELECT(imm_sel),
        .O_IMMEDIATE(imm),
        .O_OPCODE(op),
        .O_HALTED(halted),
        .O_ILLEGAL(illegal)
    );

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  op;
        logic        isel;
        logic [15:0] imm;
        logic [15:0] we;
        logic [15:0] npc;
        logic        ill;
        logic        halt;
    } exp_t;

    // Instruction-level semantics: what one instruction does to the outputs and PC.
    function automatic exp_t model(logic [15:0] ins, logic [15:0] pc, logic [4:0] fl);
        exp_t e;
        int   c;
        int   rdn;
        int   disp;
        bit   tk;
        bit   cc, ll, zz, nn;
        c    = int'(ins[15:12]);
        rdn  = int'(ins[11:8]);
        disp = int'(ins[7:0]);
        if (disp > 127) disp = disp - 256;
        cc = fl[4]; ll = fl[3]; zz = fl[1]; nn = fl[0];
        e.a = 0; e.b = 0; e.op = 0; e.isel = 0; e.imm = 0;
        e.we = 0; e.ill = 0; e.halt = 0;
        e.npc = 16'((int'(pc) + 1) % 65536);
        if (c == 0) begin
            e.a = ins[11:8]; e.b = ins[3:0]; e.op = ins[7:4];
            if (ins[7:4] != 4'd11) e.we = 16'(1 << rdn);
        end else if (c == 1 || c == 9 || c == 2 || c == 3 || c == 11) begin
            e.a = ins[11:8]; e.isel = 1; e.we = 16'(1 << rdn);
            if (c == 1 || c == 9) e.imm = 16'(disp & 16'hFFFF);
            else                  e.imm = {8'h00, ins[7:0]};
            case (c)
                1:       e.op = 4'd0;
                9:       e.op = 4'd4;
                2:       e.op = 4'd6;
                3:       e.op = 4'd7;
                default: e.op = 4'd8;
            endcase
        end else if (c == 12) begin
            case (rdn)
                0: tk = zz;   1: tk = !zz;
                2: tk = cc;   3: tk = !cc;
                4: tk = ll;   5: tk = !ll;
                6: tk = nn;   7: tk = !nn;
                14: tk = 1;
                default: tk = 0;
            endcase
            if (tk) e.npc = 16'((int'(pc) + disp + 65536) % 65536);
        end else if (c == 15) begin
            e.halt = 1;
        end else begin
            e.ill = 1;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enter in S_FETCH (1 time unit after an edge); leave in the next S_FETCH.
    task automatic run(logic [15:0] ins, logic [4:0] fl, int dly, bit drop);
        exp_t e;
        e = model(ins, mpc, fl);
        chk("fetch_req", 16'(req), 16'd1);
        chk("fetch_addr", addr, mpc);
        valid = 1'b0;
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("wait_req", 16'(req), 16'd1);
            chk("wait_addr", addr, mpc);
        end
        instr = ins;
        valid = 1'b1;
        flags = fl;
        tick();
        valid = 1'b0;
        instr = 16'($urandom);
        chk("dec_a", 16'(a_sel), 16'(e.a));
        chk("dec_b", 16'(b_sel), 16'(e.b));
        chk("dec_isel", 16'(imm_sel), 16'(e.isel));
        chk("dec_imm", imm, e.imm);
        chk("dec_op", 16'(op), 16'(e.op));
        chk("dec_we", we, 16'h0000);
        chk("dec_req", 16'(req), 16'd0);
        tick();
        if (drop) begin
            enable = 1'b0;
            #1;
            chk("hold_we", we, 16'h0000);
            chk("hold_ill", 16'(illegal), 16'd0);
            repeat (2) tick();
            chk("hold_we2", we, 16'h0000);
            chk("hold_a", 16'(a_sel), 16'(e.a));
            chk("hold_addr", addr, mpc);
            enable = 1'b1;
            #1;
        end
        chk("exe_we", we, e.we);
        chk("exe_ill", 16'(illegal), 16'(e.ill));
        chk("exe_a", 16'(a_sel), 16'(e.a));
        chk("exe_imm", imm, e.imm);
        tick();
        chk("post_we", we, 16'h0000);
        chk("post_ill", 16'(illegal), 16'd0);
        if (e.halt) begin
            chk("halt_flag", 16'(halted), 16'd1);
            chk("halt_req", 16'(req), 16'd0);
        end else begin
            chk("next_req", 16'(req), 16'd1);
            chk("next_addr", addr, e.npc);
            chk("not_halted", 16'(halted), 16'd0);
            mpc = e.npc;
        end
    endtask

    task automatic reset_and_start();
        rst_n = 1'b0;
        #1;
        chk("rst_we", we, 16'h0000);
        chk("rst_addr", addr, 16'h0000);
        chk("rst_req", 16'(req), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        tick();
        chk("start_req", 16'(req), 16'd1);
        chk("start_addr", addr, 16'h0000);
        mpc = 16'h0000;
    endtask

    task automatic advance_to(logic [15:0] target);
        for (int i = 0; i < 40 && mpc != target; i++)
            run(16'h2100 | 16'($urandom_range(0, 255)), 5'h00, 0, 0);
        chk("advance_pc", addr, target);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        valid  = 1'b0;
        instr  = 16'h0000;
        flags  = 5'h00;
        mpc    = 16'h0000;
        #2;
        chk("rst_a", 16'(a_sel), 16'd0);
        chk("rst_imm", imm, 16'h0000);
        chk("rst_op", 16'(op), 16'd0);
        chk("rst_ill", 16'(illegal), 16'd0);
        tick();
        rst_n = 1'b1;
        valid = 1'b1;
        tick();
        chk("idle_req", 16'(req), 16'd0);
        valid = 1'b0;
        enable = 1'b1;
        tick();
        chk("first_req", 16'(req), 16'd1);
        chk("first_addr", addr, 16'h0000);

        run(16'h1305, 5'h00, 0, 0);
        chk("addi_next_pc", addr, 16'h0001);
        run(16'h12FF, 5'h00, 0, 0);
        run(16'h22FF, 5'h00, 0, 0);
        run(16'h0465, 5'h00, 0, 0);
        run(16'h04B5, 5'h00, 0, 0);
        run(16'h7000, 5'h00, 0, 0);
        run(16'h3A5C, 5'h00, 3, 0);
        run(16'h0C27, 5'h00, 0, 1);

        advance_to(16'h0010);
        run(16'hC0FC, 5'b00010, 0, 0);
        chk("beq_taken", addr, 16'h000C);
        advance_to(16'h0010);
        run(16'hC0FC, 5'b11101, 0, 0);
        chk("beq_not_taken", addr, 16'h0011);
        run(16'hCEEF, 5'h00, 0, 0);
        chk("br_to_zero", addr, 16'h0000);
        run(16'hCEFF, 5'h00, 1, 0);
        chk("br_wrap_down", addr, 16'hFFFF);
        run(16'hCE02, 5'h00, 0, 0);
        chk("br_wrap_up", addr, 16'h0001);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] ins;
            ins = {4'($urandom_range(0, 14)), 12'($urandom)};
            run(ins, 5'($urandom), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of an execute cycle.
        instr = 16'h1A01;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("pre_abort_we", we, 16'h0400);
        rst_n = 1'b0;
        #1;
        chk("abort_we", we, 16'h0000);
        chk("abort_addr", addr, 16'h0000);
        tick();
        chk("abort_we2", we, 16'h0000);
        reset_and_start();

        run(16'h1101, 5'h00, 0, 0);
        run(16'hF000, 5'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            valid = i[0];
            tick();
            chk("halt_stay", 16'(halted), 16'd1);
            chk("halt_noreq", 16'(req), 16'd0);
            chk("halt_nowe", we, 16'h0000);
        end
        valid = 1'b0;
        reset_and_start();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cr16_control_fsm.md
# cr16_control_fsm

Multi-cycle control sequencer that drives the CR16 datapath. It fetches 16-bit instructions over a valid/request handshake and decodes them. It then generates the datapath control bundle: one-hot register write enable, A/B register selects, immediate value and select, and ALU opcode. It also keeps the program counter and resolves conditional branches from the datapath status flags.

## Interface
- no parameters
- I_CLK  input  1  system clock, rising edge
- I_NRESET  input  1  asynchronous active-low reset
- I_ENABLE  input  1  global enable; low freezes state, PC and IR
- O_INSTR_REQ  output  1  instruction fetch request
- O_INSTR_ADDR  output  16  fetch address (PC)
- I_INSTR_VALID  input  1  instruction data valid
- I_INSTRUCTION  input  16  instruction word
- I_STATUS_FLAGS  input  5  datapath flags {C,L,F,Z,N}, bit4..bit0
- O_REG_WRITE_ENABLE  output  16  one-hot register write strobe
- O_REG_A_SELECT  output  4  ALU A operand register
- O_REG_B_SELECT  output  4  ALU B operand register
- O_IMMEDIATE_SELECT  output  1  1 = B operand is O_IMMEDIATE
- O_IMMEDIATE  output  16  extended immediate
- O_OPCODE  output  4  datapath ALU opcode
- O_HALTED  output  1  high in S_HALT
- O_ILLEGAL  output  1  one-cycle pulse on undefined instruction

## Operation
- Instruction fields: [15:12] class, [11:8] Rd/cond, [7:4] ext, [3:0] Rs; imm8/disp8 = [7:0].
- Class 0x0 (R-type):
  - O_OPCODE = ext, A = Rd, B = Rs, IMM_SELECT = 0.
  - Writes Rd, except ext = 4'b1011 (CMP), which performs no write.
- Immediate classes: A = Rd, IMM_SELECT = 1, write Rd.
  - 0x1 ADDI: op 0000, imm8 sign-extended.
  - 0x9 SUBI: op 0100, imm8 sign-extended.
  - 0x2 ANDI: op 0110, imm8 zero-extended.
  - 0x3 ORI: op 0111, imm8 zero-extended.
  - 0xB XORI: op 1000, imm8 zero-extended.
- Class 0xC Bcond: cond = [11:8], target = PC + sext(disp8) modulo 2^16; no register write.
  - Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 14 always.
  - All other cond codes are never taken.
- Class 0xF: HALT.
- All other classes are illegal. Treat as NOP: pulse O_ILLEGAL in S_EXECUTE, no write, PC+1.
- States: S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT.
  - S_IDLE → S_FETCH when I_ENABLE = 1.
  - S_FETCH: O_INSTR_REQ = 1, O_INSTR_ADDR = PC. On I_INSTR_VALID, latch I_INSTRUCTION into IR and go to S_DECODE; otherwise stay.
  - S_DECODE: drive selects/opcode/immediate from IR, write enable 0 → S_EXECUTE.
  - S_EXECUTE: hold the same selects. Assert write enable 1<<Rd for exactly one cycle. Update PC (branch target or PC+1). Go to S_FETCH, or S_HALT for HALT.
  - S_HALT: terminal state; leave only by reset.
- Control outputs are decoded from state and IR. O_REG_WRITE_ENABLE is zero outside S_EXECUTE.
- I_ENABLE = 0 holds state, PC and IR.
  - Forces O_REG_WRITE_ENABLE = 0, O_INSTR_REQ = 0 and O_ILLEGAL = 0.
  - Selects hold their values.
  - Execution resumes in the held state.

## Timing
- Reset, asynchronous:
  - state = S_IDLE, PC = 0x0000, IR = 0x0000.
  - All outputs 0, except O_INSTR_ADDR = 0.
- Fetch handshake: request held until valid. Valid sampled at a rising edge while req = 1 completes the fetch. Valid while req = 0 is ignored.
- Minimum instruction latency is 4 cycles: S_FETCH with same-cycle valid, S_DECODE, S_EXECUTE, next S_FETCH.
- The register write and PC update happen on the edge ending S_EXECUTE.
- Branch flags are sampled in S_EXECUTE. They reflect the previous instruction's ALU result.
- PC wraps: 0xFFFF + 1 = 0x0000. A branch with negative disp from 0x0000 wraps to the top of the address space.
- Reset asserted mid-instruction aborts immediately. No write enable appears after reset assertion.

## Test plan
- Reset then enable, I_INSTRUCTION = 0x1305 valid at first fetch:
  - Expect O_INSTR_ADDR = 0, then decode with A = 3, IMM_SELECT = 1, O_IMMEDIATE = 0x0005, op 0000.
  - Then O_REG_WRITE_ENABLE = 0x0008 for one cycle; next fetch at PC = 1.
- 0x12FF (ADDI r2, -1): O_IMMEDIATE = 0xFFFF. 0x22FF (ANDI): O_IMMEDIATE = 0x00FF.
- R-type 0x0465 (op 0110, Rd = 4, Rs = 5): A = 4, B = 5, write 0x0010. 0x04B5 (CMP): write enable stays 0.
- Bcond at PC = 0x0010:
  - 0xC0FC with Z = 1 → next fetch 0x000C.
  - Same instruction with Z = 0 → 0x0011.
  - 0xCE02 at PC = 0xFFFF → 0x0001.
- Valid withheld 3 cycles in S_FETCH → req stays 1 and address stable. I_ENABLE dropped in S_EXECUTE → write suppressed, resumes on re-enable.
- 0x7000 → O_ILLEGAL one-cycle pulse, no write, PC+1. 0xF000 → O_HALTED = 1 forever, req = 0, until I_NRESET low.
